// File: rtl/map_background_writer.sv
// Rectangle-fill engine: clips a rectangle to the square map and streams one
// palette-index write per unstalled cycle, row-major, into the background index RAM.
module map_background_writer #(
    parameter int unsigned MAP_BITS = 8,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MAP_BITS-1:0]   cmd_x0,
    input  logic [MAP_BITS-1:0]   cmd_y0,
    input  logic [MAP_BITS:0]     cmd_w,
    input  logic [MAP_BITS:0]     cmd_h,
    input  logic [IDX_W-1:0]      cmd_index,
    input  logic                  wr_stall,
    output logic                  wr_en,
    output logic [2*MAP_BITS-1:0] wr_addr,
    output logic [IDX_W-1:0]      wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned SZ_W = MAP_BITS + 1;
    localparam logic [SZ_W-1:0] MAP_SIZE = {1'b1, {MAP_BITS{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [MAP_BITS-1:0] cur_x_q, cur_x_d;
    logic [MAP_BITS-1:0] cur_y_q, cur_y_d;
    logic [MAP_BITS-1:0] x_start_q, x_start_d;
    logic [MAP_BITS-1:0] x_last_q, x_last_d;
    logic [MAP_BITS-1:0] y_last_q, y_last_d;
    logic [IDX_W-1:0]    index_q, index_d;

    logic [SZ_W-1:0]     rem_x_c, rem_y_c;
    logic [SZ_W-1:0]     w_eff_c, h_eff_c;
    logic [MAP_BITS-1:0] x_last_c, y_last_c;

    // Clip the incoming command to the map; the last column/row never wraps past the edge.
    always_comb begin
        rem_x_c  = MAP_SIZE - {1'b0, cmd_x0};
        rem_y_c  = MAP_SIZE - {1'b0, cmd_y0};
        w_eff_c  = (cmd_w < rem_x_c) ? cmd_w : rem_x_c;
        h_eff_c  = (cmd_h < rem_y_c) ? cmd_h : rem_y_c;
        x_last_c = MAP_BITS'({1'b0, cmd_x0} + w_eff_c - SZ_W'(1));
        y_last_c = MAP_BITS'({1'b0, cmd_y0} + h_eff_c - SZ_W'(1));
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            x_start_q <= '0;
            x_last_q  <= '0;
            y_last_q  <= '0;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            x_start_q <= x_start_d;
            x_last_q  <= x_last_d;
            y_last_q  <= y_last_d;
            index_q   <= index_d;
        end
    end

    // Next state and outputs; outputs depend only on state registers and wr_stall.
    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        x_start_d = x_start_q;
        x_last_d  = x_last_q;
        y_last_d  = y_last_q;
        index_d   = index_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    index_d   = cmd_index;
                    cur_x_d   = cmd_x0;
                    cur_y_d   = cmd_y0;
                    x_start_d = cmd_x0;
                    x_last_d  = x_last_c;
                    y_last_d  = y_last_c;
                    if ((w_eff_c == '0) || (h_eff_c == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                busy    = 1'b1;
                wr_en   = !wr_stall;
                wr_addr = {cur_y_q, cur_x_q};
                wr_data = index_q;
                if (!wr_stall) begin
                    if (cur_x_q != x_last_q) begin
                        cur_x_d = cur_x_q + MAP_BITS'(1);
                    end else if (cur_y_q != y_last_q) begin
                        cur_x_d = x_start_q;
                        cur_y_d = cur_y_q + MAP_BITS'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
